// File: rtl/micro_pkg.sv
// Shared definitions for the result display stage: FSM encoding and display constants.
package micro_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam int         DIGITS    = 3;

endpackage

// File: rtl/result_display_seg7_decoder.sv
// Combinational BCD to active-low seven-segment decoder (gfedcba) with blanking.
module seg7_decoder
  import micro_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg = 7'h40;
        4'd1:    seg = 7'h79;
        4'd2:    seg = 7'h24;
        4'd3:    seg = 7'h30;
        4'd4:    seg = 7'h19;
        4'd5:    seg = 7'h12;
        4'd6:    seg = 7'h02;
        4'd7:    seg = 7'h78;
        4'd8:    seg = 7'h00;
        4'd9:    seg = 7'h10;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/result_display.sv
// Captures an 8-bit result, converts it to BCD by sequential double-dabble and
// scans it onto a 3-digit multiplexed seven-segment display.
module result_display
  import micro_pkg::*;
#(
  parameter int REFRESH_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  result,
  input  logic        result_valid,
  output logic        busy,
  output logic [11:0] bcd,
  output logic        bcd_valid,
  output logic [6:0]  seg,
  output logic [2:0]  an
);

  localparam int CNT_W = $clog2(REFRESH_CYCLES);

  state_t           state;
  logic [2:0]       iter;
  logic             shown;
  logic [7:0]       shreg;
  logic [11:0]      work;
  logic [11:0]      work_adj;
  logic [11:0]      work_next;
  logic [7:0]       shreg_next;
  logic [CNT_W-1:0] refresh_cnt;
  logic [1:0]       digit_idx;
  logic [3:0]       digit;
  logic             digit_blank;
  logic [6:0]       digit_seg;

  // Add 3 to every nibble >= 5; each nibble is adjusted independently.
  function automatic logic [11:0] add3(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign work_adj                = add3(work);
  assign {work_next, shreg_next} = {work_adj, shreg} << 1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      iter      <= 3'd0;
      busy      <= 1'b0;
      bcd       <= 12'h000;
      bcd_valid <= 1'b0;
      shown     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (result_valid) begin
            iter      <= 3'd0;
            busy      <= 1'b1;
            bcd_valid <= 1'b0;
            state     <= CONVERT;
          end
        end
        CONVERT: begin
          iter <= iter + 3'd1;
          if (iter == 3'd7) begin
            bcd       <= work_next;
            bcd_valid <= 1'b1;
            shown     <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Working registers carry no reset: a restart always reloads them on capture.
  always_ff @(posedge clk) begin
    if (state != CONVERT && result_valid) begin
      shreg <= result;
      work  <= 12'h000;
    end else if (state == CONVERT) begin
      shreg <= shreg_next;
      work  <= work_next;
    end
  end

  always_comb begin
    digit       = bcd[3:0];
    digit_blank = !shown;
    case (digit_idx)
      2'd1: begin
        digit       = bcd[7:4];
        digit_blank = !shown || (bcd[11:4] == 8'h00);
      end
      2'd2: begin
        digit       = bcd[11:8];
        digit_blank = !shown || (bcd[11:8] == 4'h0);
      end
      default: ;
    endcase
  end

  seg7_decoder u_decoder (
    .digit (digit),
    .blank (digit_blank),
    .seg   (digit_seg)
  );

  // Scanner stage: seg/an are registered from the current digit index and bcd.
  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_cnt <= '0;
      digit_idx   <= 2'd0;
      seg         <= SEG_BLANK;
      an          <= 3'b111;
    end else begin
      if (refresh_cnt == CNT_W'(REFRESH_CYCLES - 1)) begin
        refresh_cnt <= '0;
        digit_idx   <= (digit_idx == 2'd2) ? 2'd0 : digit_idx + 2'd1;
      end else begin
        refresh_cnt <= refresh_cnt + CNT_W'(1);
      end
      seg <= digit_seg;
      an  <= shown ? ~(3'b001 << digit_idx) : 3'b111;
    end
  end

endmodule

// File: tb/tb_result_display.sv
// Directed plus randomized bench for result_display against a transaction-level model.
module tb_result_display;

  localparam int R = 4;

  logic        clk          = 1'b0;
  logic        reset        = 1'b1;
  logic [7:0]  result       = 8'h00;
  logic        result_valid = 1'b0;
  logic        busy;
  logic [11:0] bcd;
  logic        bcd_valid;
  logic [6:0]  seg;
  logic [2:0]  an;

  int checks = 0;
  int errors = 0;
  string phase = "init";

  result_display #(.REFRESH_CYCLES(R)) dut (
    .clk          (clk),
    .reset        (reset),
    .result       (result),
    .result_valid (result_valid),
    .busy         (busy),
    .bcd          (bcd),
    .bcd_valid    (bcd_valid),
    .seg          (seg),
    .an           (an)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  // Reference model: conversion is a countdown, display value kept as an integer.
  int         m_k     = 0;
  int         m_left  = 0;
  int         m_val   = 0;
  int         m_disp  = 0;
  bit         m_busy  = 1'b0;
  bit         m_valid = 1'b0;
  bit         m_shown = 1'b0;
  logic [6:0] m_seg   = 7'h7F;
  logic [2:0] m_an    = 3'b111;

  function automatic logic [11:0] to_bcd(int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  function automatic logic [6:0] digit_seg(int v, int idx, bit shown);
    int d;
    bit blank;
    d = v % 10;
    blank = 1'b0;
    if (idx == 1) begin
      d = (v / 10) % 10;
      blank = (v < 10);
    end else if (idx == 2) begin
      d = v / 100;
      blank = (v < 100);
    end
    if (!shown || blank) return 7'h7F;
    return seg_tab[d];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_k     <= 0;
      m_left  <= 0;
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_shown <= 1'b0;
      m_disp  <= 0;
      m_seg   <= 7'h7F;
      m_an    <= 3'b111;
    end else begin
      m_seg <= digit_seg(m_disp, (m_k / R) % 3, m_shown);
      m_an  <= m_shown ? ~(3'b001 << ((m_k / R) % 3)) : 3'b111;
      m_k   <= m_k + 1;
      if (m_busy) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_busy  <= 1'b0;
          m_disp  <= m_val;
          m_valid <= 1'b1;
          m_shown <= 1'b1;
        end
      end else if (result_valid) begin
        m_val   <= int'(result);
        m_busy  <= 1'b1;
        m_left  <= 8;
        m_valid <= 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s [%s]: observed %0h expected %0h", tag, phase, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    chk("model.busy",  busy,      m_busy);
    chk("model.valid", bcd_valid, m_valid);
    chk("model.bcd",   bcd,       to_bcd(m_disp));
    chk("model.seg",   seg,       m_seg);
    chk("model.an",    an,        m_an);
  endtask

  task automatic strobe(input logic [7:0] v);
    result       = v;
    result_valid = 1'b1;
    step();
    result_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".busy"},  busy,      32'd0);
    chk({tag, ".bcd"},   bcd,       32'h000);
    chk({tag, ".valid"}, bcd_valid, 32'd0);
    chk({tag, ".seg"},   seg,       32'h7F);
    chk({tag, ".an"},    an,        32'b111);
  endtask

  initial begin
    bit found;

    phase = "reset";
    reset = 1'b1;
    step();
    step();
    check_reset_values("rst");
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      check_reset_values("idle");
    end

    phase = "full";
    strobe(8'd255);
    chk("full.busy_e0", busy, 32'd1);
    chk("full.valid_e0", bcd_valid, 32'd0);
    for (int i = 1; i < 8; i++) begin
      step();
      chk("full.busy", busy, 32'd1);
    end
    step();
    chk("full.busy_e8", busy, 32'd0);
    chk("full.bcd", bcd, 32'h255);
    chk("full.valid", bcd_valid, 32'd1);
    for (int i = 0; i < 3 * R + 2; i++) begin
      step();
      if (an == 3'b110)      chk("full.ones", seg, 32'h12);
      else if (an == 3'b101) chk("full.tens", seg, 32'h12);
      else if (an == 3'b011) chk("full.hund", seg, 32'h24);
    end

    phase = "blank";
    strobe(8'd7);
    repeat (8) step();
    chk("blank.bcd", bcd, 32'h007);
    for (int i = 0; i < 3 * R + 2; i++) begin
      step();
      if (an == 3'b110)      chk("blank.ones", seg, 32'h78);
      else if (an != 3'b111) chk("blank.lead", seg, 32'h7F);
    end

    phase = "drop";
    strobe(8'd200);
    step();
    step();
    strobe(8'd13);
    repeat (5) step();
    chk("drop.bcd", bcd, 32'h200);
    chk("drop.busy", busy, 32'd0);
    chk("drop.valid", bcd_valid, 32'd1);
    repeat (10) step();
    chk("drop.bcd_hold", bcd, 32'h200);

    phase = "midreset";
    strobe(8'd99);
    repeat (3) step();
    reset        = 1'b1;
    result       = 8'd55;
    result_valid = 1'b1;
    step();
    result_valid = 1'b0;
    reset        = 1'b0;
    check_reset_values("mid");
    strobe(8'd0);
    repeat (8) step();
    chk("mid.bcd", bcd, 32'h000);
    chk("mid.valid", bcd_valid, 32'd1);
    found = 1'b0;
    for (int i = 0; i < 3 * R + 3 && !found; i++) begin
      step();
      if (an == 3'b110) begin
        chk("mid.ones", seg, 32'h40);
        found = 1'b1;
      end
    end
    chk("mid.ones_seen", found, 32'd1);

    phase = "b2b";
    strobe(8'd100);
    repeat (7) step();
    step();
    chk("b2b.bcd1", bcd, 32'h100);
    chk("b2b.valid1", bcd_valid, 32'd1);
    strobe(8'd99);
    chk("b2b.bcd_hold", bcd, 32'h100);
    chk("b2b.valid_low", bcd_valid, 32'd0);
    chk("b2b.busy", busy, 32'd1);
    for (int i = 0; i < 7; i++) begin
      step();
      chk("b2b.valid_conv", bcd_valid, 32'd0);
    end
    step();
    chk("b2b.bcd2", bcd, 32'h099);
    chk("b2b.valid2", bcd_valid, 32'd1);
    found = 1'b0;
    for (int i = 0; i < 3 * R + 3; i++) begin
      step();
      if (an == 3'b011) begin
        chk("b2b.hund_blank", seg, 32'h7F);
        found = 1'b1;
      end else if (an == 3'b101) begin
        chk("b2b.tens", seg, 32'h10);
      end
    end
    chk("b2b.hund_seen", found, 32'd1);

    phase = "random";
    for (int i = 0; i < 600; i++) begin
      result       = 8'($urandom);
      result_valid = ($urandom_range(0, 3) == 0);
      reset        = ($urandom_range(0, 79) == 0);
      step();
    end
    result_valid = 1'b0;
    reset        = 1'b0;
    repeat (12) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/result_display.md
# result_display

Downstream output stage of the dedicated microprocessor. It captures the 8-bit result from the data path and converts it to three BCD digits with a sequential shift-add-3 (double-dabble) engine. It then drives a time-multiplexed, active-low 3-digit seven-segment display. It holds the last completed value on the display while a new conversion runs.

## Interface
- REFRESH_CYCLES, default 50000: clock cycles each digit stays enabled; must be ≥ 2.
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- result  in  8  unsigned result from the data path.
- result_valid  in  1  single-cycle strobe; `result` is stable while it is high.
- busy  out  1  conversion in progress.
- bcd  out  12  last completed value as {hundreds, tens, ones}.
- bcd_valid  out  1  `bcd` holds a completed conversion of the most recently accepted result.
- seg  out  7  segment drive, active-low, seg[6]=g … seg[0]=a.
- an  out  3  digit enables, active-low; an[0]=ones, an[2]=hundreds.

## Operation
- Reset values:
  - FSM in IDLE.
  - busy=0, bcd=12'h000, bcd_valid=0.
  - seg=7'h7F, an=3'b111.
  - Refresh counter 0, digit index 0.
  - Internal `shown` flag 0.
- FSM states are IDLE, CONVERT and DONE.
- IDLE or DONE, when result_valid=1:
  - Load a working shift register with `result`.
  - Clear the working BCD to 0 and the iteration counter to 0.
  - Set bcd_valid=0, busy=1, and go to CONVERT.
- CONVERT, one iteration per cycle:
  - Add 3 to each working BCD nibble that is ≥ 5.
  - Then shift {BCD, shift register} left by 1.
  - After iteration 8: copy the working BCD to `bcd`, set bcd_valid=1, shown=1, busy=0, and go to DONE.
- result_valid while in CONVERT is ignored and the value is dropped. Upstream must wait for busy=0.
- `bcd` changes only on conversion completion. The display keeps showing the previous value during CONVERT.
- Arithmetic:
  - The working BCD is 12 bits. Each add-3 is confined to its own nibble; there is no carry across nibbles.
  - Maximum result 255 gives 12'h255. No overflow is possible.
- Display scanner:
  - Runs in every state.
  - The refresh counter counts 0..REFRESH_CYCLES-1 and then wraps.
  - On wrap, the digit index advances 0→1→2→0.
  - an = ~(3'b001 << index).
- Segment data:
  - shown=0: all digits are blank, seg=7'h7F, and an stays 3'b111.
  - Hundreds digit: blank (seg=7'h7F) when it is 0.
  - Tens digit: blank when both hundreds and tens are 0.
  - Ones digit: never blank.
- Decode table (gfedcba, active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10. Any other nibble decodes to 7F.

## Timing
- Capture edge E0 is the edge where result_valid=1 is sampled in IDLE or DONE.
- After E0: busy=1 and bcd_valid=0.
- Iterations occur on edges E1..E8.
- After E8: bcd is updated, bcd_valid=1, busy=0. Latency is 8 cycles from capture to valid.
- Back-to-back: result_valid in the first cycle after E8 (state DONE) is accepted. Sustained throughput is one result per 9 cycles.
- seg and an are registered. They change one cycle after a refresh wrap or after a `bcd` update.
- Reset asserted in any state, including mid-CONVERT: on the next edge all outputs return to their reset values and any partial conversion is discarded.
- A simultaneous reset and result_valid: reset wins.

## Structure
- Shared package `micro_pkg` holds:
  - State encoding: IDLE=2'd0, CONVERT=2'd1, DONE=2'd2.
  - Blank segment constant 7'h7F.
  - Digit-count constant 3.
- One sub-module, `seg7_decoder`: purely combinational, 4-bit BCD in, blank flag in, 7-bit active-low segments out.
- The FSM, double-dabble engine and scanner are in the top module.

## Test plan
- Reset and idle:
  - Stimulus: hold reset for 2 cycles, then release.
  - Response: busy=0, bcd=000, bcd_valid=0, seg=7F and an=111 for 20 cycles with no input.
- Full scale:
  - Stimulus: result=255 strobed at E0.
  - Response: busy=1 for exactly 8 cycles; after E8, bcd=12'h255 and bcd_valid=1.
  - Scan with REFRESH_CYCLES=4: an steps 110→101→011 every 4 cycles with seg 12, 12, 24.
- Leading-zero blanking:
  - Stimulus: result=7.
  - Response: bcd=12'h007; ones shows seg=78; tens and hundreds show seg=7F while enabled.
- Drop during conversion:
  - Stimulus: result=200 at E0, then result=13 strobed at E3.
  - Response: bcd=12'h200 after E8; busy=0; the second value is not converted.
- Reset mid-operation:
  - Stimulus: result=99, then reset at E4.
  - Response: all outputs return to their reset values.
  - Follow-up: result=0 strobed afterwards gives bcd=12'h000, bcd_valid=1, and ones shows seg=40.
- Back-to-back:
  - Stimulus: result=100, then result=99 strobed in the cycle right after completion.
  - Response: bcd reads 12'h100 for exactly one cycle with bcd_valid=1.
  - Response: bcd_valid is 0 during the second conversion while the display still shows 100.
  - Response: bcd=12'h099 after 8 more cycles, with hundreds blanked.
